// File: rtl/dbg_conf_wb_arb.sv
// Two-master Wibone arbiter in front of the shared network-adapter configuration slave.
// Round-robin grant held for the whole cyc, with a stall watchdog that answers the owner with err.
module dbg_conf_wb_arb #(
   parameter int unsigned TIMEOUT    = 255,
   parameter int unsigned ADDR_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [31:0]           m0_adr_i,
   input  logic [31:0]           m0_dat_i,
   input  logic [3:0]            m0_sel_i,
   input  logic                  m0_cyc_i,
   input  logic                  m0_stb_i,
   input  logic                  m0_we_i,
   output logic [31:0]           m0_dat_o,
   output logic                  m0_ack_o,
   output logic                  m0_err_o,
   output logic                  m0_rty_o,
   input  logic [31:0]           m1_adr_i,
   input  logic [31:0]           m1_dat_i,
   input  logic [3:0]            m1_sel_i,
   input  logic                  m1_cyc_i,
   input  logic                  m1_stb_i,
   input  logic                  m1_we_i,
   output logic [31:0]           m1_dat_o,
   output logic                  m1_ack_o,
   output logic                  m1_err_o,
   output logic                  m1_rty_o,
   output logic [ADDR_WIDTH-1:0] s_adr_o,
   output logic [31:0]           s_dat_o,
   output logic [3:0]            s_sel_o,
   output logic                  s_cyc_o,
   output logic                  s_stb_o,
   output logic                  s_we_o,
   input  logic [31:0]           s_dat_i,
   input  logic                  s_ack_i,
   input  logic                  s_err_i,
   input  logic                  s_rty_i,
   output logic [1:0]            gnt_o
);

   typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_TOUT} state_t;

   localparam logic [7:0] TOUT_LIM = 8'(TIMEOUT);

   state_t      state_q, state_d;
   logic [1:0]  gnt_q, gnt_d;
   logic        last_q, last_d;
   logic [7:0]  cnt_q, cnt_d;
   logic        err_done_q, err_done_d;
   logic        win1;

   logic [31:0] g_adr, g_dat;
   logic [3:0]  g_sel;
   logic        g_cyc, g_stb, g_we;
   logic        s_rsp, busy, tout;
   logic [7:0]  cnt_inc;
   logic        unused_adr;

   assign g_adr   = gnt_q[1] ? m1_adr_i : m0_adr_i;
   assign g_dat   = gnt_q[1] ? m1_dat_i : m0_dat_i;
   assign g_sel   = gnt_q[1] ? m1_sel_i : m0_sel_i;
   assign g_cyc   = gnt_q[1] ? m1_cyc_i : m0_cyc_i;
   assign g_stb   = gnt_q[1] ? m1_stb_i : m0_stb_i;
   assign g_we    = gnt_q[1] ? m1_we_i  : m0_we_i;
   assign s_rsp   = s_ack_i | s_err_i | s_rty_i;
   assign busy    = (state_q == ST_BUSY);
   assign tout    = (state_q == ST_TOUT);
   assign cnt_inc = cnt_q + 8'd1;
   assign unused_adr = ^g_adr;

   always_comb begin
      state_d    = state_q;
      gnt_d      = gnt_q;
      last_d     = last_q;
      cnt_d      = 8'd0;
      err_done_d = err_done_q;
      win1       = 1'b0;
      case (state_q)
         ST_IDLE: begin
            err_done_d = 1'b0;
            if (m0_cyc_i || m1_cyc_i) begin
               // a lone requester always wins; on a tie the master not served last wins
               win1    = m1_cyc_i & (~m0_cyc_i | ~last_q);
               gnt_d   = win1 ? 2'b10 : 2'b01;
               last_d  = win1;
               state_d = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (!g_cyc) begin
               state_d = ST_IDLE;
               gnt_d   = 2'b00;
            end else if (g_stb && !s_rsp) begin
               cnt_d = cnt_inc;
               if (cnt_inc == TOUT_LIM) begin
                  state_d = ST_TOUT;
                  cnt_d   = 8'd0;
               end
            end
         end
         ST_TOUT: begin
            err_done_d = 1'b1;
            if (!g_cyc) begin
               state_d    = ST_IDLE;
               gnt_d      = 2'b00;
               err_done_d = 1'b0;
            end
         end
         default: begin
            state_d = ST_IDLE;
            gnt_d   = 2'b00;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         gnt_q      <= 2'b00;
         last_q     <= 1'b1;
         cnt_q      <= 8'd0;
         err_done_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         gnt_q      <= gnt_d;
         last_q     <= last_d;
         cnt_q      <= cnt_d;
         err_done_q <= err_done_d;
      end
   end

   always_comb begin
      s_adr_o  = '0;
      s_dat_o  = 32'd0;
      s_sel_o  = 4'd0;
      s_cyc_o  = 1'b0;
      s_stb_o  = 1'b0;
      s_we_o   = 1'b0;
      m0_dat_o = 32'd0;
      m0_ack_o = 1'b0;
      m0_err_o = 1'b0;
      m0_rty_o = 1'b0;
      m1_dat_o = 32'd0;
      m1_ack_o = 1'b0;
      m1_err_o = 1'b0;
      m1_rty_o = 1'b0;
      if (busy) begin
         s_adr_o = g_adr[ADDR_WIDTH-1:0];
         s_dat_o = g_dat;
         s_sel_o = g_sel;
         s_cyc_o = g_cyc;
         s_stb_o = g_stb;
         s_we_o  = g_we;
         if (gnt_q[0]) begin
            m0_dat_o = s_dat_i;
            m0_ack_o = s_ack_i;
            m0_err_o = s_err_i;
            m0_rty_o = s_rty_i;
         end
         if (gnt_q[1]) begin
            m1_dat_o = s_dat_i;
            m1_ack_o = s_ack_i;
            m1_err_o = s_err_i;
            m1_rty_o = s_rty_i;
         end
      end else if (tout && !err_done_q) begin
         m0_err_o = gnt_q[0];
         m1_err_o = gnt_q[1];
      end
   end

   assign gnt_o = gnt_q;

endmodule
